// File: rtl/keypad_scan_display.sv
// Multiplexed 7-segment driver fed by a keypad entry buffer: digit 0 holds the newest key,
// older digits shift upward, and the buffer is scanned onto active-low enables and segments.
module keypad_scan_display #(
    parameter int DIGITS   = 8,
    parameter int SCAN_CNT = 20000,
    localparam int CW      = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [1:0]            key_op,
    input  logic [3:0]            key_num,
    output logic [DIGITS-1:0]     led_en,
    output logic [7:0]            led_cx,
    output logic [4*DIGITS-1:0]   value,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  err
);

    localparam int IW = $clog2(DIGITS);
    localparam int SW = $clog2(SCAN_CNT + 1);

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_BKSP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_DP    = 2'b11;

    // Segment pattern {a..g,dp}, active-low, decimal point off.
    function automatic logic [7:0] hex_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0:    s = 8'h03;
            4'h1:    s = 8'h9F;
            4'h2:    s = 8'h25;
            4'h3:    s = 8'h0D;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h49;
            4'h6:    s = 8'h41;
            4'h7:    s = 8'h1F;
            4'h8:    s = 8'h01;
            4'h9:    s = 8'h19;
            4'hA:    s = 8'h11;
            4'hB:    s = 8'hC1;
            4'hC:    s = 8'hE5;
            4'hD:    s = 8'h85;
            4'hE:    s = 8'h61;
            4'hF:    s = 8'h71;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [SW-1:0]            cnt_r;
    logic [IW-1:0]            idx_r;
    logic [IW-1:0]            next_idx_s;
    logic                     tick_s;
    logic [DIGITS-1:0]        led_en_r;
    logic [7:0]               led_cx_r;
    logic [DIGITS-1:0]        next_en_s;
    logic [7:0]               next_cx_s;
    logic [7:0]               hex_s;
    logic [DIGITS-1:0][3:0]   digit_r;
    logic [DIGITS-1:0]        dp_r;
    logic [CW-1:0]            count_r;
    logic                     err_r;
    logic [4*DIGITS-1:0]      value_s;

    // Scan tick and the digit position it will select.
    always_comb begin
        tick_s = (cnt_r == SW'(SCAN_CNT));
        if (idx_r == IW'(DIGITS - 1)) begin
            next_idx_s = '0;
        end else begin
            next_idx_s = idx_r + IW'(1);
        end
    end

    // Enable and segment pattern for the next position, taken from the pre-op buffer.
    always_comb begin
        next_en_s             = '1;
        next_en_s[next_idx_s] = 1'b0;
        hex_s                 = hex_seg(digit_r[next_idx_s]);
        if (CW'(next_idx_s) < count_r) begin
            next_cx_s = {hex_s[7:1], ~dp_r[next_idx_s]};
        end else if ((count_r == '0) && (next_idx_s == '0)) begin
            next_cx_s = 8'h03;
        end else begin
            next_cx_s = 8'hFF;
        end
    end

    // Scan counter, position index and the registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= SW'(1);
            idx_r    <= IW'(DIGITS - 1);
            led_en_r <= '1;
            led_cx_r <= 8'hFF;
        end else if (tick_s) begin
            cnt_r    <= SW'(1);
            idx_r    <= next_idx_s;
            led_en_r <= next_en_s;
            led_cx_r <= next_cx_s;
        end else begin
            cnt_r    <= cnt_r + SW'(1);
        end
    end

    // Entry buffer; err flags a rejected key op for the following cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_r <= '0;
            dp_r    <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (key_valid) begin
                case (key_op)
                    OP_PUSH: begin
                        if (count_r < CW'(DIGITS)) begin
                            digit_r <= {digit_r[DIGITS-2:0], key_num};
                            dp_r    <= {dp_r[DIGITS-2:0], 1'b0};
                            count_r <= count_r + CW'(1);
                        end else begin
                            err_r   <= 1'b1;
                        end
                    end
                    OP_BKSP: begin
                        if (count_r != '0) begin
                            digit_r <= {4'h0, digit_r[DIGITS-1:1]};
                            dp_r    <= {1'b0, dp_r[DIGITS-1:1]};
                            count_r <= count_r - CW'(1);
                        end else begin
                            err_r   <= 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        digit_r <= '0;
                        dp_r    <= '0;
                        count_r <= '0;
                    end
                    OP_DP: begin
                        if (count_r != '0) begin
                            dp_r[0] <= ~dp_r[0];
                        end else begin
                            err_r   <= 1'b1;
                        end
                    end
                    default: begin
                        err_r <= 1'b0;
                    end
                endcase
            end else begin
                err_r <= 1'b0;
            end
        end
    end

    // Packed value with positions beyond the entered count forced to zero.
    always_comb begin
        value_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (CW'(i) < count_r) begin
                value_s[4*i +: 4] = digit_r[i];
            end else begin
                value_s[4*i +: 4] = 4'h0;
            end
        end
    end

    assign led_en = led_en_r;
    assign led_cx = led_cx_r;
    assign value  = value_s;
    assign count  = count_r;
    assign full   = (count_r == CW'(DIGITS));
    assign err    = err_r;

endmodule

// File: tb/tb_keypad_scan_display.sv
// Self-checking bench for keypad_scan_display: vector table, directed display sequences and
// randomized key traffic against a queue-based reference model.
module tb_keypad_scan_display;

    localparam int D  = 4;
    localparam int S  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [1:0]    key_op;
    logic [3:0]    key_num;
    logic [D-1:0]  led_en;
    logic [7:0]    led_cx;
    logic [4*D-1:0] value;
    logic [CW-1:0] count;
    logic          full;
    logic          err;

    always #5 clk = ~clk;

    keypad_scan_display #(.DIGITS(D), .SCAN_CNT(S)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_op(key_op), .key_num(key_num),
        .led_en(led_en), .led_cx(led_cx), .value(value), .count(count), .full(full), .err(err)
    );

    int        n_cmp = 0;
    int        n_bad = 0;
    int        edge_n;
    bit        tick_now;
    int        q_dig[$];
    bit        q_dp[$];
    logic [3:0] m_en;
    logic [7:0] m_cx;
    logic      m_err;
    logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h19, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  num;
        int          exp_cnt;
        logic [15:0] exp_val;
        logic        exp_err;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_exp(input int i);
        if (i < q_dig.size()) return hex_tab[q_dig[i]] ^ {7'd0, q_dp[i]};
        else if (q_dig.size() == 0 && i == 0) return 8'h03;
        else return 8'hFF;
    endfunction

    function automatic logic [15:0] val_exp();
        logic [15:0] v = 16'h0;
        for (int i = 0; i < q_dig.size(); i++) v = v | (16'(q_dig[i]) << (4 * i));
        return v;
    endfunction

    task automatic model_reset();
        q_dig.delete();
        q_dp.delete();
        edge_n = 0;
        m_en   = 4'hF;
        m_cx   = 8'hFF;
        m_err  = 1'b0;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [3:0] num);
        case (op)
            2'b00: if (q_dig.size() < D) begin q_dig.push_front(int'(num)); q_dp.push_front(1'b0); end
                   else m_err = 1'b1;
            2'b01: if (q_dig.size() > 0) begin void'(q_dig.pop_front()); void'(q_dp.pop_front()); end
                   else m_err = 1'b1;
            2'b10: begin q_dig.delete(); q_dp.delete(); end
            default: if (q_dig.size() > 0) q_dp[0] = !q_dp[0];
                     else m_err = 1'b1;
        endcase
    endtask

    task automatic check_all();
        chk("led_en", 32'(led_en), 32'(m_en));
        chk("led_cx", 32'(led_cx), 32'(m_cx));
        chk("value",  32'(value),  32'(val_exp()));
        chk("count",  32'(count),  32'(q_dig.size()));
        chk("full",   32'(full),   32'(q_dig.size() == D));
        chk("err",    32'(err),    32'(m_err));
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] num);
        int sel;
        key_valid = v;
        key_op    = op;
        key_num   = num;
        @(posedge clk);
        edge_n++;
        tick_now = (edge_n % S == 0);
        if (tick_now) begin
            sel  = (edge_n / S - 1) % D;
            m_en = 4'hF & ~(4'b0001 << sel);
            m_cx = seg_exp(sel);
        end
        m_err = 1'b0;
        if (v) model_op(op, num);
        #1;
        key_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0);
    endtask

    initial begin
        logic [7:0] old_cx;
        int         sel0;

        vt[0]  = '{2'b00, 4'h1, 1, 16'h0001, 1'b0};
        vt[1]  = '{2'b00, 4'h2, 2, 16'h0012, 1'b0};
        vt[2]  = '{2'b00, 4'h3, 3, 16'h0123, 1'b0};
        vt[3]  = '{2'b00, 4'h4, 4, 16'h1234, 1'b0};
        vt[4]  = '{2'b00, 4'h5, 4, 16'h1234, 1'b1};
        vt[5]  = '{2'b01, 4'h0, 3, 16'h0123, 1'b0};
        vt[6]  = '{2'b01, 4'h0, 2, 16'h0012, 1'b0};
        vt[7]  = '{2'b01, 4'h0, 1, 16'h0001, 1'b0};
        vt[8]  = '{2'b01, 4'h0, 0, 16'h0000, 1'b0};
        vt[9]  = '{2'b01, 4'h0, 0, 16'h0000, 1'b1};
        vt[10] = '{2'b11, 4'h0, 0, 16'h0000, 1'b1};
        vt[11] = '{2'b00, 4'h7, 1, 16'h0007, 1'b0};
        vt[12] = '{2'b11, 4'h0, 1, 16'h0007, 1'b0};
        vt[13] = '{2'b00, 4'h4, 2, 16'h0074, 1'b0};
        vt[14] = '{2'b10, 4'h0, 0, 16'h0000, 1'b0};
        vt[15] = '{2'b10, 4'h0, 0, 16'h0000, 1'b0};

        rst = 1'b0; key_valid = 1'b0; key_op = 2'b00; key_num = 4'h0;
        model_reset();
        #12;
        chk("rst_led_en", 32'(led_en), 32'h0000_000F);
        chk("rst_led_cx", 32'(led_cx), 32'h0000_00FF);
        chk("rst_count",  32'(count),  32'h0);
        chk("rst_err",    32'(err),    32'h0);
        rst = 1'b1;

        // First tick lands on the S-th edge after release and selects digit 0.
        for (int i = 0; i < S - 1; i++) begin
            step(1'b0, 2'b00, 4'h0);
            chk("pre_tick_en", 32'(led_en), 32'h0000_000F);
        end
        step(1'b0, 2'b00, 4'h0);
        chk("first_tick_en", 32'(led_en), 32'h0000_000E);
        chk("first_tick_cx", 32'(led_cx), 32'h0000_0003);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, vt[i].op, vt[i].num);
            chk("tbl_count", 32'(count), 32'(vt[i].exp_cnt));
            chk("tbl_value", 32'(value), 32'(vt[i].exp_val));
            chk("tbl_err",   32'(err),   32'(vt[i].exp_err));
        end

        // Entered 1,2,3 seen across a full scan.
        step(1'b1, 2'b00, 4'h1); step(1'b1, 2'b00, 4'h2); step(1'b1, 2'b00, 4'h3);
        for (int i = 0; i < 2 * D * S; i++) begin
            step(1'b0, 2'b00, 4'h0);
            if (tick_now) begin
                case (m_en)
                    4'hE:    chk("scan123_d0", 32'(led_cx), 32'h0D);
                    4'hD:    chk("scan123_d1", 32'(led_cx), 32'h25);
                    4'hB:    chk("scan123_d2", 32'(led_cx), 32'h9F);
                    default: chk("scan123_d3", 32'(led_cx), 32'hFF);
                endcase
            end
        end

        // Decimal point follows its digit when it shifts up.
        step(1'b1, 2'b10, 4'h0); step(1'b1, 2'b00, 4'h7); step(1'b1, 2'b11, 4'h0);
        for (int i = 0; i < D * S; i++) begin
            step(1'b0, 2'b00, 4'h0);
            if (tick_now && m_en == 4'hE) chk("dp7_d0", 32'(led_cx), 32'h1E);
        end
        step(1'b1, 2'b00, 4'h4);
        for (int i = 0; i < D * S; i++) begin
            step(1'b0, 2'b00, 4'h0);
            if (tick_now && m_en == 4'hD) chk("dp7_d1", 32'(led_cx), 32'h1E);
            if (tick_now && m_en == 4'hE) chk("four_d0", 32'(led_cx), 32'h99);
        end

        // Clear on a tick edge: that slot keeps the pre-clear pattern.
        step(1'b1, 2'b00, 4'h1); step(1'b1, 2'b00, 4'h2); step(1'b1, 2'b00, 4'h3);
        while ((edge_n + 1) % S != 0) step(1'b0, 2'b00, 4'h0);
        sel0   = ((edge_n + 1) / S - 1) % D;
        old_cx = seg_exp(sel0);
        step(1'b1, 2'b10, 4'h0);
        chk("clr_tick_old", 32'(led_cx), 32'(old_cx));
        chk("clr_count", 32'(count), 32'h0);
        for (int i = 0; i < D * S; i++) begin
            step(1'b0, 2'b00, 4'h0);
            if (tick_now) chk("clr_blank", 32'(led_cx), (m_en == 4'hE) ? 32'h03 : 32'hFF);
        end

        // Held key_valid repeats the op each cycle.
        for (int i = 0; i < D + 2; i++) step(1'b1, 2'b00, 4'h9);
        chk("held_full", 32'(full), 32'h1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        // Reset mid-scan with a key op pending.
        #2;
        key_valid = 1'b1; key_op = 2'b00; key_num = 4'h5;
        rst = 1'b0;
        #1;
        chk("async_led_en", 32'(led_en), 32'h0000_000F);
        chk("async_led_cx", 32'(led_cx), 32'h0000_00FF);
        chk("async_count",  32'(count),  32'h0);
        chk("async_value",  32'(value),  32'h0);
        key_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < S - 1; i++) step(1'b0, 2'b00, 4'h0);
        chk("rerst_pre_tick", 32'(led_en), 32'h0000_000F);
        step(1'b0, 2'b00, 4'h0);
        chk("rerst_tick_en", 32'(led_en), 32'h0000_000E);
        idle(D * S);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
